// File: rtl/ooo_commit_pkg.sv
// Shared types for the commit-side register-file scheduler: FSM state
// encoding, queue entry layout and default field widths.
package ooo_commit_pkg;

  localparam int AR_SIZE_D = 6;
  localparam int DATA_W_D  = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [AR_SIZE_D-1:0] addr;
    logic [DATA_W_D-1:0]  data;
    logic [AR_SIZE_D-1:0] old;
  } entry_t;

endpackage

// File: rtl/commit_fifo_2w2r.sv
// Circular buffer with two write ports and two read ports. Lane 1 is only
// written together with lane 0. The read ports always show the two oldest
// entries, and rd_cnt retires 0..2 of them.
module commit_fifo_2w2r #(
  parameter int W     = 44,
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int OW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr0_en,
  input  logic          wr1_en,
  input  logic [W-1:0]  wr0_dat,
  input  logic [W-1:0]  wr1_dat,
  input  logic [1:0]    rd_cnt,
  output logic [W-1:0]  rd0_dat,
  output logic [W-1:0]  rd1_dat,
  output logic [OW-1:0] occ,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr1;
  logic [PW-1:0] rd_ptr1;
  logic [1:0]    wr_cnt;

  assign wr_ptr1 = wr_ptr + PW'(1);
  assign rd_ptr1 = rd_ptr + PW'(1);
  assign wr_cnt  = {1'b0, wr0_en} + {1'b0, wr1_en};

  assign rd0_dat = mem[rd_ptr];
  assign rd1_dat = mem[rd_ptr1];
  assign empty   = (occ == '0);
  assign full    = (occ == OW'(DEPTH));

  // Storage is data only; it carries no reset.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr_ptr]  <= wr0_dat;
    if (wr1_en) mem[wr_ptr1] <= wr1_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_cnt);
      rd_ptr <= rd_ptr + PW'(rd_cnt);
      occ    <= occ + OW'(wr_cnt) - OW'(rd_cnt);
    end
  end

endmodule

// File: rtl/arf_commit_sched.sv
// Commit scheduler: buffers up to two retiring results per cycle and drives
// the register-file dual write port, oldest entry on slot 1.
module arf_commit_sched
  import ooo_commit_pkg::*;
#(
  parameter int AR_SIZE = AR_SIZE_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in0_valid,
  input  logic [AR_SIZE-1:0] in0_addr,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic [AR_SIZE-1:0] in0_old,
  input  logic               in1_valid,
  input  logic [AR_SIZE-1:0] in1_addr,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic [AR_SIZE-1:0] in1_old,
  output logic               in_ready,
  input  logic               hold_req,
  output logic               hold_ack,
  input  logic               flush,
  output logic               write_en,
  output logic [AR_SIZE-1:0] write_addr1,
  output logic [DATA_W-1:0]  write_data1,
  output logic [AR_SIZE-1:0] old_addr1,
  output logic [AR_SIZE-1:0] write_addr2,
  output logic [DATA_W-1:0]  write_data2,
  output logic [AR_SIZE-1:0] old_addr2,
  output logic               q_empty,
  output logic               q_full,
  output logic               lane_err,
  output logic [CNT_W-1:0]   commit_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int EW = 2 * AR_SIZE + DATA_W;

  state_t state, state_nxt;

  logic [OW-1:0]      occ;
  logic               push0, push1;
  logic               pop_en;
  logic [1:0]         pop_cnt;
  logic [EW-1:0]      rd0_dat, rd1_dat;
  logic [AR_SIZE-1:0] rd0_addr, rd1_addr, rd0_old, rd1_old;
  logic [DATA_W-1:0]  rd0_data, rd1_data;

  logic               vld_p1;
  logic [AR_SIZE-1:0] addr1_p1, old1_p1, addr2_p1, old2_p1;
  logic [DATA_W-1:0]  data1_p1, data2_p1;
  logic [CNT_W-1:0]   cnt_p1;
  logic               lane_err_p1;

  // Count of popped entries that actually update the register file.
  function automatic logic [1:0] nz_cnt(input logic [1:0] n,
                                        input logic [AR_SIZE-1:0] a0,
                                        input logic [AR_SIZE-1:0] a1);
    logic [1:0] c;
    c = 2'd0;
    if (n >= 2'd1 && a0 != '0) c = c + 2'd1;
    if (n == 2'd2 && a1 != '0) c = c + 2'd1;
    return c;
  endfunction

  // Room for a full pair is required even when only one lane is valid.
  assign in_ready = (occ <= OW'(DEPTH - 2)) && (state != FLUSH) && !flush;
  assign push0    = in_ready && in0_valid;
  assign push1    = in_ready && in0_valid && in1_valid;

  // Only entries present before this edge are popped, so there is no bypass.
  assign pop_en  = (state == RUN) && !hold_req && !flush;
  assign pop_cnt = !pop_en        ? 2'd0 :
                   (occ >= OW'(2)) ? 2'd2 : {1'b0, occ[0]};

  commit_fifo_2w2r #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr0_en  (push0),
    .wr1_en  (push1),
    .wr0_dat ({in0_addr, in0_data, in0_old}),
    .wr1_dat ({in1_addr, in1_data, in1_old}),
    .rd_cnt  (pop_cnt),
    .rd0_dat (rd0_dat),
    .rd1_dat (rd1_dat),
    .occ     (occ),
    .empty   (q_empty),
    .full    (q_full)
  );

  assign {rd0_addr, rd0_data, rd0_old} = rd0_dat;
  assign {rd1_addr, rd1_data, rd1_old} = rd1_dat;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FLUSH;
    end else begin
      unique case (state)
        RUN:     state_nxt = hold_req ? HOLD : RUN;
        HOLD:    state_nxt = hold_req ? HOLD : RUN;
        FLUSH:   state_nxt = hold_req ? HOLD : RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // p1: registered write-port slots; an unused slot is driven to all zeros.
  always_ff @(posedge clk) begin
    if (rst || flush || pop_cnt == 2'd0) begin
      vld_p1   <= 1'b0;
      addr1_p1 <= '0;
      data1_p1 <= '0;
      old1_p1  <= '0;
      addr2_p1 <= '0;
      data2_p1 <= '0;
      old2_p1  <= '0;
    end else begin
      vld_p1   <= 1'b1;
      addr1_p1 <= rd0_addr;
      data1_p1 <= rd0_data;
      old1_p1  <= rd0_old;
      addr2_p1 <= (pop_cnt == 2'd2) ? rd1_addr : '0;
      data2_p1 <= (pop_cnt == 2'd2) ? rd1_data : '0;
      old2_p1  <= (pop_cnt == 2'd2) ? rd1_old  : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1      <= '0;
      lane_err_p1 <= 1'b0;
    end else begin
      cnt_p1 <= cnt_p1 + CNT_W'(nz_cnt(pop_cnt, rd0_addr, rd1_addr));
      if (in_ready && in1_valid && !in0_valid) lane_err_p1 <= 1'b1;
    end
  end

  assign hold_ack    = (state == HOLD);
  assign write_en    = vld_p1;
  assign write_addr1 = addr1_p1;
  assign write_data1 = data1_p1;
  assign old_addr1   = old1_p1;
  assign write_addr2 = addr2_p1;
  assign write_data2 = data2_p1;
  assign old_addr2   = old2_p1;
  assign commit_cnt  = cnt_p1;
  assign lane_err    = lane_err_p1;

endmodule

// File: tb/tb_arf_commit_sched.sv
// Directed vector bench for arf_commit_sched: a table of per-cycle inputs
// and expected outputs, plus short hand-written flush/hold and reset sequences.
module tb_arf_commit_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in1_valid;
  logic [5:0]  in0_addr, in0_old, in1_addr, in1_old;
  logic [31:0] in0_data, in1_data;
  logic        in_ready, hold_req, hold_ack, flush;
  logic        write_en;
  logic [5:0]  write_addr1, old_addr1, write_addr2, old_addr2;
  logic [31:0] write_data1, write_data2;
  logic        q_empty, q_full, lane_err;
  logic [31:0] commit_cnt;

  int total = 0;
  int bad   = 0;
  int row   = -1;

  always #5 clk = ~clk;

  arf_commit_sched #(.AR_SIZE(6), .DATA_W(32), .DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_addr(in0_addr), .in0_data(in0_data), .in0_old(in0_old),
    .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_data(in1_data), .in1_old(in1_old),
    .in_ready(in_ready), .hold_req(hold_req), .hold_ack(hold_ack), .flush(flush),
    .write_en(write_en),
    .write_addr1(write_addr1), .write_data1(write_data1), .old_addr1(old_addr1),
    .write_addr2(write_addr2), .write_data2(write_data2), .old_addr2(old_addr2),
    .q_empty(q_empty), .q_full(q_full), .lane_err(lane_err), .commit_cnt(commit_cnt)
  );

  typedef struct {
    logic        hold, fl;
    logic        v0; logic [5:0] a0; logic [31:0] d0; logic [5:0] o0;
    logic        v1; logic [5:0] a1; logic [31:0] d1; logic [5:0] o1;
    logic        rdy, we;
    logic [5:0]  wa1; logic [31:0] wd1; logic [5:0] wo1;
    logic [5:0]  wa2; logic [31:0] wd2; logic [5:0] wo2;
    logic        emp, full, hack, lerr;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(
      input logic hold, input logic fl,
      input logic v0, input int a0, input int d0, input int o0,
      input logic v1, input int a1, input int d1, input int o1,
      input logic rdy, input logic we,
      input int wa1, input int wd1, input int wo1,
      input int wa2, input int wd2, input int wo2,
      input logic emp, input logic full, input logic hack, input logic lerr,
      input int cnt);
    vec_t r;
    r.hold = hold; r.fl = fl;
    r.v0 = v0; r.a0 = 6'(a0); r.d0 = 32'(d0); r.o0 = 6'(o0);
    r.v1 = v1; r.a1 = 6'(a1); r.d1 = 32'(d1); r.o1 = 6'(o1);
    r.rdy = rdy; r.we = we;
    r.wa1 = 6'(wa1); r.wd1 = 32'(wd1); r.wo1 = 6'(wo1);
    r.wa2 = 6'(wa2); r.wd2 = 32'(wd2); r.wo2 = 6'(wo2);
    r.emp = emp; r.full = full; r.hack = hack; r.lerr = lerr;
    r.cnt = 32'(cnt);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", nm, row, act, exp);
    end
  endtask

  task automatic drive_idle();
    hold_req = 1'b0; flush = 1'b0;
    in0_valid = 1'b0; in0_addr = '0; in0_data = '0; in0_old = '0;
    in1_valid = 1'b0; in1_addr = '0; in1_data = '0; in1_old = '0;
  endtask

  task automatic chk_outs(input vec_t e);
    chk("write_en",    32'(write_en),    32'(e.we));
    chk("write_addr1", 32'(write_addr1), 32'(e.wa1));
    chk("write_data1", write_data1,      e.wd1);
    chk("old_addr1",   32'(old_addr1),   32'(e.wo1));
    chk("write_addr2", 32'(write_addr2), 32'(e.wa2));
    chk("write_data2", write_data2,      e.wd2);
    chk("old_addr2",   32'(old_addr2),   32'(e.wo2));
    chk("q_empty",     32'(q_empty),     32'(e.emp));
    chk("q_full",      32'(q_full),      32'(e.full));
    chk("hold_ack",    32'(hold_ack),    32'(e.hack));
    chk("lane_err",    32'(lane_err),    32'(e.lerr));
    chk("commit_cnt",  commit_cnt,       e.cnt);
  endtask

  initial begin
    //            hold fl  v0 a0  d0      o0  v1 a1  d1      o1  rdy we  wa1 wd1     wo1 wa2 wd2     wo2 emp full hack lerr cnt
    tbl.push_back(V(0,0, 1,5, 'h1234,3,  0,0, 0,     0,  1,0, 0, 0,     0,  0, 0,     0,  0,0,0,0, 0));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,1, 5, 'h1234,3,  0, 0,     0,  1,0,0,0, 1));
    tbl.push_back(V(0,0, 1,1, 'h10,  11, 1,2, 'h20,  12, 1,0, 0, 0,     0,  0, 0,     0,  0,0,0,0, 1));
    tbl.push_back(V(0,0, 1,3, 'h30,  13, 1,4, 'h40,  14, 1,1, 1, 'h10,  11, 2, 'h20,  12, 0,0,0,0, 3));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,1, 3, 'h30,  13, 4, 'h40,  14, 1,0,0,0, 5));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,0, 0, 0,     0,  0, 0,     0,  1,0,0,0, 5));
    // hold: fill the queue, nothing drains
    tbl.push_back(V(1,0, 1,16,'h100, 1,  1,17,'h101, 2,  1,0, 0, 0,     0,  0, 0,     0,  0,0,1,0, 5));
    tbl.push_back(V(1,0, 1,18,'h102, 3,  1,19,'h103, 4,  1,0, 0, 0,     0,  0, 0,     0,  0,0,1,0, 5));
    tbl.push_back(V(1,0, 1,20,'h104, 5,  1,21,'h105, 6,  1,0, 0, 0,     0,  0, 0,     0,  0,0,1,0, 5));
    tbl.push_back(V(1,0, 1,22,'h106, 7,  1,23,'h107, 8,  1,0, 0, 0,     0,  0, 0,     0,  0,1,1,0, 5));
    tbl.push_back(V(1,0, 1,50,'h1,   1,  1,51,'h2,   2,  0,0, 0, 0,     0,  0, 0,     0,  0,1,1,0, 5));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  0,0, 0, 0,     0,  0, 0,     0,  0,1,0,0, 5));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  0,1, 16,'h100, 1,  17,'h101, 2,  0,0,0,0, 7));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,1, 18,'h102, 3,  19,'h103, 4,  0,0,0,0, 9));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,1, 20,'h104, 5,  21,'h105, 6,  0,0,0,0, 11));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,1, 22,'h106, 7,  23,'h107, 8,  1,0,0,0, 13));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,0, 0, 0,     0,  0, 0,     0,  1,0,0,0, 13));
    // flush with five queued entries and a valid push on the flush cycle
    tbl.push_back(V(1,0, 1,30,'h200, 0,  1,31,'h201, 0,  1,0, 0, 0,     0,  0, 0,     0,  0,0,1,0, 13));
    tbl.push_back(V(1,0, 1,32,'h202, 0,  1,33,'h203, 0,  1,0, 0, 0,     0,  0, 0,     0,  0,0,1,0, 13));
    tbl.push_back(V(1,0, 1,34,'h204, 0,  0,0, 0,     0,  1,0, 0, 0,     0,  0, 0,     0,  0,0,1,0, 13));
    tbl.push_back(V(0,1, 1,40,'h300, 0,  1,41,'h301, 0,  0,0, 0, 0,     0,  0, 0,     0,  1,0,0,0, 13));
    tbl.push_back(V(0,0, 1,42,'h302, 0,  1,43,'h303, 0,  0,0, 0, 0,     0,  0, 0,     0,  1,0,0,0, 13));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,0, 0, 0,     0,  0, 0,     0,  1,0,0,0, 13));
    // address 0 is written but not counted
    tbl.push_back(V(0,0, 1,0, 'h55,  1,  1,7, 'h77,  2,  1,0, 0, 0,     0,  0, 0,     0,  0,0,0,0, 13));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,1, 0, 'h55,  1,  7, 'h77,  2,  1,0,0,0, 14));
    // lane 1 without lane 0
    tbl.push_back(V(0,0, 0,0, 0,     0,  1,9, 'h99,  1,  1,0, 0, 0,     0,  0, 0,     0,  1,0,0,1, 14));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,0, 0, 0,     0,  0, 0,     0,  1,0,0,1, 14));
    // same destination in both slots, younger value on slot 2
    tbl.push_back(V(0,0, 1,9, 'hAA,  1,  1,9, 'hBB,  2,  1,0, 0, 0,     0,  0, 0,     0,  0,0,0,1, 14));
    tbl.push_back(V(0,0, 0,0, 0,     0,  0,0, 0,     0,  1,1, 9, 'hAA,  1,  9, 'hBB,  2,  1,0,0,1, 16));

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset write_en",   32'(write_en),   0);
    chk("reset write_addr1", 32'(write_addr1), 0);
    chk("reset q_empty",    32'(q_empty),    1);
    chk("reset q_full",     32'(q_full),     0);
    chk("reset hold_ack",   32'(hold_ack),   0);
    chk("reset commit_cnt", commit_cnt,      0);
    chk("reset in_ready",   32'(in_ready),   1);

    for (int i = 0; i < tbl.size(); i++) begin
      row = i;
      @(negedge clk);
      hold_req = tbl[i].hold; flush = tbl[i].fl;
      in0_valid = tbl[i].v0; in0_addr = tbl[i].a0; in0_data = tbl[i].d0; in0_old = tbl[i].o0;
      in1_valid = tbl[i].v1; in1_addr = tbl[i].a1; in1_data = tbl[i].d1; in1_old = tbl[i].o1;
      #1;
      chk("in_ready", 32'(in_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk_outs(tbl[i]);
    end

    // flush with hold asserted: FLUSH for one cycle, then HOLD, then RUN
    row = 100;
    @(negedge clk);
    drive_idle(); flush = 1'b1; hold_req = 1'b1;
    @(posedge clk); #1;
    chk("flush+hold hold_ack", 32'(hold_ack), 0);
    chk("flush+hold q_empty",  32'(q_empty),  1);
    @(negedge clk);
    flush = 1'b0; hold_req = 1'b1;
    #1 chk("in_ready in FLUSH", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("after flush hold_ack", 32'(hold_ack), 1);
    @(negedge clk);
    hold_req = 1'b0;
    @(posedge clk); #1;
    chk("hold release hold_ack", 32'(hold_ack), 0);

    // reset in mid-stream drops queued entries and clears the counters
    row = 101;
    @(negedge clk);
    in0_valid = 1'b1; in0_addr = 6'd5; in0_data = 32'h5; in0_old = 6'd1;
    in1_valid = 1'b1; in1_addr = 6'd6; in1_data = 32'h6; in1_old = 6'd2;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    chk("pre-rst write_en",   32'(write_en),    1);
    chk("pre-rst write_addr2", 32'(write_addr2), 6);
    chk("pre-rst commit_cnt", commit_cnt,       18);
    @(negedge clk);
    in0_valid = 1'b1; in0_addr = 6'd11; in0_data = 32'h11; in0_old = 6'd3;
    in1_valid = 1'b1; in1_addr = 6'd12; in1_data = 32'h12; in1_old = 6'd4;
    @(posedge clk);
    @(negedge clk);
    drive_idle(); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst write_en",    32'(write_en),    0);
    chk("rst write_addr1", 32'(write_addr1), 0);
    chk("rst write_data1", write_data1,      0);
    chk("rst write_addr2", 32'(write_addr2), 0);
    chk("rst commit_cnt",  commit_cnt,       0);
    chk("rst lane_err",    32'(lane_err),    0);
    chk("rst q_empty",     32'(q_empty),     1);
    chk("rst hold_ack",    32'(hold_ack),    0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst write_en", 32'(write_en), 0);
    chk("post-rst q_empty",  32'(q_empty),  1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
